eth_fcs_append: RTL
===================

Name: eth_fcs_append

Overview:
- TX-path stage that takes an XGMII frame stream without FCS and re-emits it with the 4-byte IEEE 802.3 FCS inserted before /T/.
- Computes the CRC internally, using the codebase CRC generator as its engine.
- Sits between the MAC TX framer and the PCS encoder.
- The stream is continuous with no handshake: exactly one beat in and one beat out per cycle.

Parameters:
- CNT_W, 32, width of the frame, runt and error counters (saturating).

Ports:
- clk  in  1  single clock; all logic is on posedge.
- rst  in  1  synchronous, active-high reset.
- in_ctrl  in  8  XGMII control, bit i = lane i.
- in_data  in  64  XGMII data, lane i = bits [8i+7:8i].
- out_ctrl  out  8  XGMII control with FCS inserted.
- out_data  out  64  XGMII data with FCS inserted.
- frame_cnt  out  CNT_W  frames emitted with FCS.
- runt_cnt  out  CNT_W  frames with fewer than 60 bytes (DA..payload).
- err_cnt  out  CNT_W  protocol errors (abort or IPG violation).

Behaviour:
- Reset (synchronous, active-high): out_ctrl=8'hFF, out_data=64'h0707070707070707 (all idle), state=IDLE, all counters 0. The same idle output holds until the first post-reset beat reaches the output.
- Fixed latency: out = in delayed exactly 2 cycles, except for the beats modified below.
- Start beat (/S/): in_ctrl==8'h01 && in_data[7:0]==8'hFB.
  - Preamble and SFD are not covered by the CRC.
  - The CRC covers every data byte from the beat after /S/ up to, but excluding, /T/.
- Terminate beat: first lane k (0..7) with ctrl=1 and byte 8'hFD while in FRAME. Lanes <k are data.
- FCS is transmitted LSB first: lane k gets FCS[7:0], then FCS[15:8], FCS[23:16], FCS[31:24] in the following lanes.
- FCS placement by k:
  - k<=3: FCS occupies lanes k..k+3 of the terminate beat; /T/ at lane k+4; lanes above k+4 are /I/.
  - k=4: FCS occupies lanes 4..7; the next beat is /T/ in lane 0 plus idles.
  - k>=5: FCS bytes 0..(7-k) go in lanes k..7. The remaining bytes go in lanes 0..k-5 of the next beat, with /T/ at lane k-4 and /I/ above it.
- Affected lanes have ctrl bits set accordingly: FCS lanes ctrl=0, /T/ and /I/ lanes ctrl=1.
- States:
  - IDLE: on /S/, pass it through and go to FRAME.
  - FRAME: on terminate with k<=4 (where k=4 means /T/ in lane 0 of the next beat), go to IDLE; with k>=5 (FCS overflows into the next beat), go to TAIL.
  - TAIL: overwrite the current beat with the FCS remainder and /T/, then go to IDLE.
- IPG rule: the input beat after a terminate with k>=4 must be all /I/ (ctrl=8'hFF, bytes 8'h07).
  - If it is not, it is overwritten anyway and err_cnt increments.
  - If that overwritten beat was an /S/, the new frame is lost.
- Abort: /S/ (or any ctrl byte other than /T/, /I/ or /E/) seen in FRAME.
  - Output at that beat position is lane 0 = /E/ (8'hFE, ctrl=1), lanes 1..7 = /I/.
  - No FCS and no /T/ are emitted; err_cnt increments; state goes to IDLE.
  - If the aborting beat was /S/, the new frame is not started.
- Counters:
  - frame_cnt increments once per emitted /T/.
  - runt_cnt increments at /T/ when the byte count is below 60; the FCS is still appended and no padding is added.
  - All counters saturate at all-ones.
- Byte counter is 16 bits, saturating, and resets on /S/.
- Reset mid-frame: output returns to idle on the cycle after rst is sampled, pipeline contents are discarded, and input is ignored until the next /S/.
- CRC engine contract: the FCS is registered and valid the cycle after the terminate beat enters. This is why the 2-cycle output delay is needed.

Decomposition:
- xgmii_pkg (existing) gains:
  - constants XGMII_START=8'hFB, XGMII_TERM=8'hFD, XGMII_IDLE=8'h07, XGMII_ERR=8'hFE;
  - XGMII_IDLE_WORD;
  - typedef fcs_app_state_t {IDLE, FRAME, TAIL}.
- Sub-module: eth_fcs_gen, instantiated as the CRC engine. Its crc_en is held high in FRAME; data_last is asserted on the terminate beat.
- Lane insertion is a local combinational mux driven by a registered k.

Test Plan:
- 9-byte frame "123456789" (terminate k=1) -> out lanes 1..4 = 26 39 F4 CB (ctrl=0), /T/ at lane 5, latency 2 cycles, runt_cnt=1, frame_cnt=1.
- 60-byte frame of 8'h00..8'h3B (k=4) -> FCS in lanes 4..7, next beat /T/ lane 0; FCS matches a zlib crc32 model; runt_cnt unchanged.
- 61-byte and 63-byte frames (k=5, k=7) -> FCS split across two beats, /T/ at lane 1 and lane 3 of the next beat respectively; FCS matches the model.
- Back-to-back 64-byte frames with a 1-beat IPG, then a k=6 frame followed immediately by /S/ -> first two frames correct; third frame's overflow beat overwrites the /S/; err_cnt=1.
- /S/ injected mid-frame -> output /E/ lane 0 at that beat position, no /T/, err_cnt=1; the next clean frame is correct.
- rst asserted for one cycle mid-frame -> output all-idle the next cycle, all counters 0; the following frame is correct.

Source files
------------

// File: rtl/xgmii_pkg.sv
// Shared XGMII characters, FCS-insertion state types and the reflected CRC-32 byte step.
package xgmii_pkg;

  localparam logic [7:0]  XGMII_START     = 8'hFB;
  localparam logic [7:0]  XGMII_TERM      = 8'hFD;
  localparam logic [7:0]  XGMII_IDLE      = 8'h07;
  localparam logic [7:0]  XGMII_ERR       = 8'hFE;
  localparam logic [63:0] XGMII_IDLE_WORD = {8{XGMII_IDLE}};

  localparam logic [31:0] CRC32_POLY      = 32'hEDB88320;
  localparam int          MIN_FRAME_BYTES = 60;

  typedef enum logic [1:0] {IDLE, FRAME, TAIL} fcs_app_state_t;

  // What the output stage does with the beat held one cycle behind the input.
  typedef enum logic [2:0] {K_PASS, K_IDLE, K_TERM, K_TAIL, K_ABORT} beat_kind_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int n = 0; n < 8; n++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_fcs_gen.sv
// CRC-32 engine over up to eight byte lanes per cycle; the complemented FCS is
// registered on the data_last beat and is stable from the following cycle.
module eth_fcs_gen
  import xgmii_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        crc_init,
  input  logic        crc_en,
  input  logic        data_last,
  input  logic [7:0]  byte_en,
  input  logic [63:0] data,
  output logic [31:0] fcs
);

  logic [31:0] crc_q, crc_d;
  logic [31:0] fcs_q, fcs_d;
  logic [31:0] crc_upd;

  always_comb begin
    crc_upd = crc_q;
    for (int i = 0; i < 8; i++) begin
      if (byte_en[i]) crc_upd = crc32_byte(crc_upd, data[8*i +: 8]);
    end
    crc_d = crc_q;
    fcs_d = fcs_q;
    if (crc_init) begin
      crc_d = '1;
    end else if (crc_en) begin
      crc_d = crc_upd;
      if (data_last) fcs_d = ~crc_upd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '1;
      fcs_q <= '0;
    end else begin
      crc_q <= crc_d;
      fcs_q <= fcs_d;
    end
  end

  assign fcs = fcs_q;

endmodule

// File: rtl/eth_fcs_append.sv
// Re-emits an XGMII TX stream two cycles later with the 802.3 FCS inserted ahead of /T/.
// The stream has no handshake: one beat is accepted and one beat is emitted every cycle.
module eth_fcs_append
  import xgmii_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_ctrl,
  input  logic [63:0]      in_data,
  output logic [7:0]       out_ctrl,
  output logic [63:0]      out_data,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] runt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  fcs_app_state_t   state_q, state_d;
  beat_kind_t       p1_kind_q, p1_kind_d;
  logic [7:0]       p1_ctrl_q, p1_ctrl_d, out_ctrl_q, out_ctrl_d;
  logic [63:0]      p1_data_q, p1_data_d, out_data_q, out_data_d;
  logic [2:0]       k_q, k_d, term_k;
  logic             tail4_q, tail4_d, discard_q, discard_d;
  logic [15:0]      byte_cnt_q, byte_cnt_d;
  logic [16:0]      term_sum, beat_sum;
  logic [CNT_W-1:0] frame_cnt_q, runt_cnt_q, err_cnt_q;
  logic [CNT_W-1:0] frame_cnt_d, runt_cnt_d, err_cnt_d;
  logic             is_start, is_idle_word, term_found, bad_ctrl;
  logic             frame_inc, runt_inc, err_inc;
  logic             crc_init, crc_en, data_last;
  logic [7:0]       byte_en;
  logic [31:0]      fcs, fcs_sh;
  int               j;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + CNT_W'(1) : v;
  endfunction

  eth_fcs_gen u_fcs_gen (
    .clk       (clk),
    .rst       (rst),
    .crc_init  (crc_init),
    .crc_en    (crc_en),
    .data_last (data_last),
    .byte_en   (byte_en),
    .data      (in_data),
    .fcs       (fcs)
  );

  // Lanes are scanned high to low so the lowest /T/ lane wins.
  always_comb begin
    is_start     = (in_ctrl == 8'h01) && (in_data[7:0] == XGMII_START);
    is_idle_word = (in_ctrl == 8'hFF) && (in_data == XGMII_IDLE_WORD);
    term_found   = 1'b0;
    term_k       = 3'd0;
    bad_ctrl     = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (in_ctrl[i] && (in_data[8*i +: 8] == XGMII_TERM)) begin
        term_found = 1'b1;
        term_k     = 3'(i);
      end
      if (in_ctrl[i] && (in_data[8*i +: 8] != XGMII_TERM) &&
          (in_data[8*i +: 8] != XGMII_IDLE) && (in_data[8*i +: 8] != XGMII_ERR)) begin
        bad_ctrl = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    p1_kind_d  = K_PASS;
    p1_ctrl_d  = in_ctrl;
    p1_data_d  = in_data;
    k_d        = k_q;
    tail4_d    = 1'b0;
    discard_d  = discard_q;
    byte_cnt_d = byte_cnt_q;
    frame_inc  = 1'b0;
    runt_inc   = 1'b0;
    err_inc    = 1'b0;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    data_last  = 1'b0;
    byte_en    = 8'hFF;
    term_sum   = {1'b0, byte_cnt_q} + {14'd0, term_k};
    beat_sum   = {1'b0, byte_cnt_q} + 17'd8;
    if ((state_q == TAIL) || tail4_q) begin
      // The beat after a k>=4 terminate carries FCS/T whatever arrived in it.
      p1_kind_d = K_TAIL;
      state_d   = IDLE;
      if (!is_idle_word) begin
        err_inc   = 1'b1;
        discard_d = 1'b1;
      end
    end else if (state_q == IDLE) begin
      if (is_start) begin
        state_d    = FRAME;
        crc_init   = 1'b1;
        byte_cnt_d = '0;
        discard_d  = 1'b0;
      end else if (discard_q) begin
        p1_kind_d = K_IDLE;
      end
    end else begin
      crc_en = 1'b1;
      if (bad_ctrl) begin
        p1_kind_d = K_ABORT;
        err_inc   = 1'b1;
        discard_d = 1'b1;
        state_d   = IDLE;
      end else if (term_found) begin
        data_last  = 1'b1;
        p1_kind_d  = K_TERM;
        k_d        = term_k;
        frame_inc  = 1'b1;
        runt_inc   = (term_sum < 17'(MIN_FRAME_BYTES));
        byte_cnt_d = term_sum[16] ? 16'hFFFF : term_sum[15:0];
        for (int i = 0; i < 8; i++) byte_en[i] = (3'(i) < term_k);
        tail4_d    = (term_k == 3'd4);
        state_d    = (term_k >= 3'd5) ? TAIL : IDLE;
      end else begin
        byte_cnt_d = beat_sum[16] ? 16'hFFFF : beat_sum[15:0];
      end
    end
    frame_cnt_d = sat_inc(frame_cnt_q, frame_inc);
    runt_cnt_d  = sat_inc(runt_cnt_q, runt_inc);
    err_cnt_d   = sat_inc(err_cnt_q, err_inc);
  end

  // j is the lane's position relative to FCS byte 0: 0..3 FCS, 4 is /T/, above is idle.
  always_comb begin
    out_ctrl_d = p1_ctrl_q;
    out_data_d = p1_data_q;
    fcs_sh     = '0;
    j          = 0;
    case (p1_kind_q)
      K_IDLE: begin
        out_ctrl_d = 8'hFF;
        out_data_d = XGMII_IDLE_WORD;
      end
      K_ABORT: begin
        out_ctrl_d = 8'hFF;
        out_data_d = {{7{XGMII_IDLE}}, XGMII_ERR};
      end
      K_TERM, K_TAIL: begin
        for (int i = 0; i < 8; i++) begin
          j = i - int'(k_q) + ((p1_kind_q == K_TAIL) ? 8 : 0);
          if ((j >= 0) && (j <= 3)) begin
            fcs_sh                = fcs >> (8 * j);
            out_ctrl_d[i]         = 1'b0;
            out_data_d[8*i +: 8]  = fcs_sh[7:0];
          end else if (j == 4) begin
            out_ctrl_d[i]         = 1'b1;
            out_data_d[8*i +: 8]  = XGMII_TERM;
          end else if (j > 4) begin
            out_ctrl_d[i]         = 1'b1;
            out_data_d[8*i +: 8]  = XGMII_IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      p1_kind_q   <= K_IDLE;
      p1_ctrl_q   <= 8'hFF;
      p1_data_q   <= XGMII_IDLE_WORD;
      k_q         <= 3'd0;
      tail4_q     <= 1'b0;
      discard_q   <= 1'b1;
      byte_cnt_q  <= '0;
      frame_cnt_q <= '0;
      runt_cnt_q  <= '0;
      err_cnt_q   <= '0;
      out_ctrl_q  <= 8'hFF;
      out_data_q  <= XGMII_IDLE_WORD;
    end else begin
      state_q     <= state_d;
      p1_kind_q   <= p1_kind_d;
      p1_ctrl_q   <= p1_ctrl_d;
      p1_data_q   <= p1_data_d;
      k_q         <= k_d;
      tail4_q     <= tail4_d;
      discard_q   <= discard_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      runt_cnt_q  <= runt_cnt_d;
      err_cnt_q   <= err_cnt_d;
      out_ctrl_q  <= out_ctrl_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_ctrl  = out_ctrl_q;
  assign out_data  = out_data_q;
  assign frame_cnt = frame_cnt_q;
  assign runt_cnt  = runt_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
